// File: rtl/alien_fleet_if.sv
// Alien movement/fire bundle between the fleet controller (master) and the alien array.
// Carries the pixel position and mode used for frame timing, plus per-alien feedback.
interface alien_fleet_if #(
   parameter int NUM_ALIENS = 9,
   parameter int TIMER_W    = 16
);
   logic [1:0]                    mode;
   logic [9:0]                    xCoord;
   logic [9:0]                    yCoord;
   logic [NUM_ALIENS-1:0]         alien_edge;
   logic [NUM_ALIENS-1:0]         alien_alive;
   logic                          move_left;
   logic                          move_right;
   logic                          move_down;
   logic [NUM_ALIENS*TIMER_W-1:0] shoot_timer;
   logic                          fleet_cleared;

   modport master (
      input  mode, xCoord, yCoord, alien_edge, alien_alive,
      output move_left, move_right, move_down, shoot_timer, fleet_cleared
   );

   modport slave (
      output mode, xCoord, yCoord, alien_edge, alien_alive,
      input  move_left, move_right, move_down, shoot_timer, fleet_cleared
   );
endinterface

// File: rtl/alien_fleet_ctrl.sv
// Fleet-level move/fire command generator for the invader aliens, stepped once per frame.
// Define FLEET_RANDOM_SHOOT_EN for LFSR-driven shoot intervals; otherwise timers are fixed.
module alien_fleet_ctrl #(
   parameter int          NUM_ALIENS    = 9,
   parameter int          TIMER_W       = 16,
   parameter int unsigned SHOOT_MIN     = 16'd300,
   parameter logic [15:0] SHOOT_MASK    = 16'h01FF,
   parameter int unsigned SHOOT_STAGGER = 16'd97,
   parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
   input  logic          clk,
   input  logic          rst,
   alien_fleet_if.master fleet_io
);

   typedef enum logic [2:0] {
      IDLE,
      RIGHT,
      DOWN_R,
      LEFT,
      DOWN_L
   } state_e;

   function automatic logic [NUM_ALIENS*TIMER_W-1:0] init_slices();
      logic [NUM_ALIENS*TIMER_W-1:0] v;
      v = '0;
      for (int i = 0; i < NUM_ALIENS; i++) begin
         v[i*TIMER_W +: TIMER_W] = TIMER_W'(SHOOT_MIN + SHOOT_STAGGER * unsigned'(i));
      end
      return v;
   endfunction

   localparam logic [NUM_ALIENS*TIMER_W-1:0] SLICE_INIT = init_slices();

   state_e state_q, state_d;
   logic   pix0, pix0_q, tick;
   logic   playing, live_edge, any_alive;
   logic   move_left_q, move_right_q, move_down_q;

   assign pix0      = (fleet_io.xCoord == 10'd0) && (fleet_io.yCoord == 10'd0);
   assign tick      = pix0 && !pix0_q;
   assign playing   = (fleet_io.mode == 2'd2);
   assign live_edge = |(fleet_io.alien_edge & fleet_io.alien_alive);
   assign any_alive = |fleet_io.alien_alive;

   // The mode check is outside the tick gate so a pause aborts immediately.
   always_comb begin
      // NOTE: default first so every path assigns state_d and no latch is inferred.
      state_d = state_q;
      if (!playing) begin
         state_d = IDLE;
      end else if (tick && any_alive) begin
         case (state_q)
            IDLE:    state_d = RIGHT;
            RIGHT:   if (live_edge)  state_d = DOWN_R;
            DOWN_R:  if (!live_edge) state_d = LEFT;
            LEFT:    if (live_edge)  state_d = DOWN_L;
            DOWN_L:  if (!live_edge) state_d = RIGHT;
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: synchronous active-high reset; all state uses non-blocking assignments.
      if (rst) begin
         state_q      <= IDLE;
         pix0_q       <= 1'b0;
         move_left_q  <= 1'b0;
         move_right_q <= 1'b0;
         move_down_q  <= 1'b0;
      end else begin
         pix0_q       <= pix0;
         state_q      <= state_d;
         move_right_q <= (state_d == RIGHT);
         move_left_q  <= (state_d == LEFT);
         move_down_q  <= (state_d == DOWN_R) || (state_d == DOWN_L);
      end
   end

   assign fleet_io.move_left     = move_left_q;
   assign fleet_io.move_right    = move_right_q;
   assign fleet_io.move_down     = move_down_q;
   assign fleet_io.fleet_cleared = ~any_alive;

`ifdef FLEET_RANDOM_SHOOT_EN
   localparam int          IDX_W     = (NUM_ALIENS > 1) ? $clog2(NUM_ALIENS) : 1;
   localparam logic [15:0] LFSR_TAPS = 16'hB400;
   localparam logic [15:0] SEED_EFF  = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;

   logic [15:0]                   lfsr_q, lfsr_d;
   logic [IDX_W-1:0]              idx_q;
   logic [NUM_ALIENS*TIMER_W-1:0] shoot_timer_q;
   logic                          advance;

   // The IDLE->RIGHT entry tick only starts the fleet; refreshes begin on the next tick.
   assign advance = playing && tick && (state_q != IDLE);
   assign lfsr_d  = lfsr_q[0] ? ((lfsr_q >> 1) ^ LFSR_TAPS) : (lfsr_q >> 1);

   always_ff @(posedge clk) begin
      if (rst || !playing) begin
         lfsr_q        <= SEED_EFF;
         idx_q         <= '0;
         shoot_timer_q <= SLICE_INIT;
      end else if (advance) begin
         lfsr_q <= lfsr_d;
         shoot_timer_q[int'(idx_q)*TIMER_W +: TIMER_W] <=
            TIMER_W'(SHOOT_MIN + 32'(lfsr_d & SHOOT_MASK));
         idx_q  <= (idx_q == IDX_W'(NUM_ALIENS - 1)) ? '0 : idx_q + 1'b1;
      end
   end

   assign fleet_io.shoot_timer = shoot_timer_q;
`else
   assign fleet_io.shoot_timer = SLICE_INIT;
`endif

endmodule

// File: tb/tb_alien_fleet_ctrl.sv
// Self-checking bench for alien_fleet_ctrl: directed frame ticks against a heading/descent model.
// Honours FLEET_RANDOM_SHOOT_EN the same way the design does.
module tb_alien_fleet_ctrl;
   localparam int          NUM       = 9;
   localparam int          TW        = 16;
   localparam int          S_MIN     = 300;
   localparam logic [15:0] S_MASK    = 16'h01FF;
   localparam int          S_STAGGER = 97;
   localparam logic [15:0] SEED      = 16'hACE1;

   logic clk;
   logic rst;
   int   errors = 0;
   int   checks = 0;
   bit   cmp_en = 1'b0;

   alien_fleet_if #(.NUM_ALIENS(NUM), .TIMER_W(TW)) bus ();

   alien_fleet_ctrl #(
      .NUM_ALIENS(NUM), .TIMER_W(TW), .SHOOT_MIN(S_MIN), .SHOOT_MASK(S_MASK),
      .SHOOT_STAGGER(S_STAGGER), .LFSR_SEED(SEED)
   ) dut (
      .clk(clk), .rst(rst), .fleet_io(bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Model: heading is +1 (right), -1 (left) or 0 (idle); descending marks a down step.
   int          m_head;
   bit          m_desc;
   bit          m_pix_q;
   logic [15:0] m_lfsr;
   int          m_idx;
   int          m_slice[NUM];

   task automatic model_reset_timers();
      for (int i = 0; i < NUM; i++) m_slice[i] = (S_MIN + i * S_STAGGER) % 65536;
      m_lfsr = SEED;
      m_idx  = 0;
   endtask

   always @(posedge clk) begin
      bit pix0, tick, live;
      pix0 = (bus.xCoord == 0) && (bus.yCoord == 0);
      live = |(bus.alien_edge & bus.alien_alive);
      if (rst) begin
         m_head  = 0;
         m_desc  = 1'b0;
         m_pix_q = 1'b0;
         model_reset_timers();
      end else begin
         tick    = pix0 && !m_pix_q;
         m_pix_q = pix0;
         if (bus.mode != 2'd2) begin
            m_head = 0;
            m_desc = 1'b0;
            model_reset_timers();
         end else if (tick) begin
`ifdef FLEET_RANDOM_SHOOT_EN
            if (m_head != 0) begin
               m_lfsr = m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
               m_slice[m_idx] = (S_MIN + int'(m_lfsr & S_MASK)) % 65536;
               m_idx = (m_idx + 1) % NUM;
            end
`endif
            if (|bus.alien_alive) begin
               if (m_head == 0) begin
                  m_head = 1;
                  m_desc = 1'b0;
               end else if (!m_desc && live) begin
                  m_desc = 1'b1;
               end else if (m_desc && !live) begin
                  m_desc = 1'b0;
                  m_head = -m_head;
               end
            end
         end
      end
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         check("move_right", bus.move_right, 32'(m_head == 1 && !m_desc));
         check("move_left", bus.move_left, 32'(m_head == -1 && !m_desc));
         check("move_down", bus.move_down, 32'(m_desc));
         check("fleet_cleared", bus.fleet_cleared, 32'(~|bus.alien_alive));
         for (int i = 0; i < NUM; i++)
            check($sformatf("slice%0d", i), bus.shoot_timer[i*TW +: TW], m_slice[i]);
      end
   end

   // Holds pixel (0,0) for `hold` clocks, then returns just after the last of those edges.
   task automatic frame_tick(input int hold);
      @(negedge clk); #1;
      bus.xCoord = 10'd0;
      bus.yCoord = 10'd0;
      repeat (hold) @(negedge clk);
      #1;
      bus.xCoord = 10'd1;
   endtask

   initial begin
      rst             = 1'b1;
      bus.mode        = 2'd2;
      bus.alien_alive = 9'h1FF;
      bus.alien_edge  = 9'h000;
      bus.xCoord      = 10'd5;
      bus.yCoord      = 10'd5;
      @(negedge clk);
      cmp_en = 1'b1;
      @(negedge clk); #1;
      check("rst_moves", {bus.move_left, bus.move_right, bus.move_down}, 0);
      check("rst_slice0", bus.shoot_timer[0*TW +: TW], 300);
      check("rst_slice1", bus.shoot_timer[1*TW +: TW], 397);
      check("rst_slice8", bus.shoot_timer[8*TW +: TW], 1076);
      rst = 1'b0;

      frame_tick(1);
      check("entry_right", bus.move_right, 1);
      check("entry_slice0", bus.shoot_timer[0 +: TW], 300);

      bus.alien_edge = 9'h008;
      frame_tick(1);
      check("edge_down", bus.move_down, 1);
`ifdef FLEET_RANDOM_SHOOT_EN
      check("lfsr_slice0", bus.shoot_timer[0 +: TW], 412);
`else
      check("fixed_slice0", bus.shoot_timer[0 +: TW], 300);
`endif
      repeat (3) begin
         frame_tick(1);
         check("down_hold", bus.move_down, 1);
      end
      bus.alien_edge = 9'h000;
      frame_tick(1);
      check("rev_left", bus.move_left, 1);

      bus.alien_edge = 9'h001;
      frame_tick(1);
      check("left_down", bus.move_down, 1);
      bus.alien_edge = 9'h000;
      frame_tick(1);
      check("rev_right", bus.move_right, 1);

      bus.alien_alive = 9'h1DF;
      bus.alien_edge  = 9'h020;
      repeat (10) begin
         frame_tick(1);
         check("dead_edge_right", bus.move_right, 1);
      end
      bus.alien_alive = 9'h1FF;
      bus.alien_edge  = 9'h000;

      bus.alien_edge = 9'h100;
      frame_tick(1);
      bus.alien_edge = 9'h000;
      frame_tick(1);
      bus.alien_edge = 9'h100;
      frame_tick(1);
      check("in_down_l", bus.move_down, 1);
      bus.alien_edge = 9'h000;
      bus.xCoord = 10'd200;
      bus.yCoord = 10'd100;
      @(negedge clk); #1;
      bus.mode = 2'd1;
      @(negedge clk); #1;
      check("pause_moves", {bus.move_left, bus.move_right, bus.move_down}, 0);
      check("pause_slice0", bus.shoot_timer[0 +: TW], 300);
      frame_tick(1);
      check("pause_tick_idle", {bus.move_left, bus.move_right, bus.move_down}, 0);
      bus.mode = 2'd2;
      frame_tick(1);
      check("resume_right", bus.move_right, 1);

      bus.alien_edge = 9'h002;
      frame_tick(1);
      bus.alien_edge = 9'h000;
      frame_tick(1);
      check("pre_clear_left", bus.move_left, 1);
      bus.alien_alive = 9'h000;
      bus.alien_edge  = 9'h1FF;
      #1;
      check("cleared", bus.fleet_cleared, 1);
      repeat (3) begin
         frame_tick(1);
         check("cleared_hold_left", bus.move_left, 1);
      end
      frame_tick(4);
      check("long_tick_left", bus.move_left, 1);

      repeat (3) @(negedge clk);
      cmp_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/alien_fleet_ctrl.md
# alien_fleet_ctrl

- Fleet-level command generator for the invader aliens.
- Drives the shared `move_left` / `move_right` / `move_down` strobes and the packed per-alien `shoot_timer` bus.
- Closes the loop on the per-alien edge flags: a fleet sweep reverses only after every live alien has acknowledged a down step.
- Sits between the VGA pixel counters and the array of alien instances in the game top level. It is the sender side of the alien movement/fire interface.

## Interface

Parameters:
- NUM_ALIENS, 9: number of alien instances served.
- TIMER_W, 16: width of one shoot-timer slice.
- SHOOT_MIN, 16'd300: minimum shoot interval in frames.
- SHOOT_MASK, 16'h01FF: mask applied to the LFSR for the random interval part. SHOOT_MIN+SHOOT_MASK must be < 2^TIMER_W.
- SHOOT_STAGGER, 16'd97: per-alien offset used when random shooting is compiled out.
- LFSR_SEED, 16'hACE1: nonzero LFSR reset value.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset: synchronous, active-high.
- mode  in  2  game mode; 2 = playing, any other value = menu/paused.
- xCoord  in  10  current pixel column.
- yCoord  in  10  current pixel row.
- alien_edge  in  NUM_ALIENS  per-alien is_edge flags.
- alien_alive  in  NUM_ALIENS  1 = alien not destroyed.
- move_left  out  1  fleet moving left (level).
- move_right  out  1  fleet moving right (level).
- move_down  out  1  fleet stepping down (level).
- shoot_timer  out  NUM_ALIENS*TIMER_W  slice i (bits i*TIMER_W +: TIMER_W) is alien i's fire interval.
- fleet_cleared  out  1  all aliens dead.

## Operation

Frame tick:
- `tick` is a single-cycle pulse on the first clk cycle of (xCoord==0 && yCoord==0), produced by registered edge detect of that condition.
- All state, LFSR and timer updates occur only on `tick`.

Live edge:
- `live_edge` = |(alien_edge & alien_alive). Dead aliens never block reversal.

FSM states, with outputs:
- IDLE: all moves 0.
- RIGHT: move_right=1.
- DOWN_R: move_down=1.
- LEFT: move_left=1.
- DOWN_L: move_down=1.

FSM transitions, evaluated on tick:
- IDLE → RIGHT when mode==2.
- RIGHT → DOWN_R when live_edge.
- DOWN_R → LEFT when !live_edge (aliens clear their flags after a down step).
- LEFT → DOWN_L when live_edge.
- DOWN_L → RIGHT when !live_edge.
- Any state → IDLE when mode!=2. This is checked every cycle, not only on tick.
- alien_alive==0: hold current state, fleet_cleared=1.

Move outputs are registered and decoded from state. Exactly one is high outside IDLE.

Shoot timers:
- 16-bit Galois LFSR, polynomial x^16+x^14+x^13+x^11+1 (toggle mask 16'hB400), shifted right once per tick in mode 2.
- Round-robin index `idx` 0..NUM_ALIENS-1. On each tick, slice[idx] <= SHOOT_MIN + (lfsr & SHOOT_MASK), truncated to TIMER_W.
- `idx` then increments, wrapping NUM_ALIENS-1 → 0.
- Each slice therefore refreshes every NUM_ALIENS frames.

## Timing

Reset values (rst, or mode!=2):
- State IDLE; all move outputs 0.
- lfsr = LFSR_SEED; idx = 0.
- slice i = SHOOT_MIN + i*SHOOT_STAGGER, truncated.
- fleet_cleared = ~|alien_alive; this is combinational and active in all states.

Latency and precedence:
- Move outputs change one clk after the tick that caused the transition.
- rst has priority over mode and tick.
- A mode drop mid-DOWN_x aborts to IDLE; re-entry always resumes at RIGHT.
- A tick coincident with an IDLE→RIGHT entry advances nothing else. LFSR and timer updates start on the next tick.
- live_edge asserted in the same tick that DOWN_x is entered has no effect until the following tick.
- The LFSR never reaches 0. A 0 seed parameter is illegal; the design substitutes 16'h0001.

## Configuration

FLEET_RANDOM_SHOOT_EN:
- Defined: LFSR and round-robin refresh active as described.
- Undefined: LFSR and idx logic are removed. Slices hold their reset values permanently (SHOOT_MIN + i*SHOOT_STAGGER).

## Test plan

- rst high 2 cycles with alien_alive=9'h1FF, mode=2 → all moves 0, slice0=300, slice1=397, slice8=1076. First tick → move_right=1 next cycle.
- RIGHT, alien_edge[3]=1 alive → next tick move_down=1. Hold edge 3 ticks → move_down stays 1. Clear edge → next tick move_left=1.
- RIGHT, alien_edge[5]=1 with alien_alive[5]=0 → stays RIGHT for 10 ticks.
- DOWN_L, mode→1 mid-frame → all moves 0 the next cycle. mode→2 → first tick gives move_right.
- Macro defined, seed 16'hACE1, 1 tick in mode 2 → LFSR = 16'hE270, slice0 = 300 + (16'hE270 & 16'h1FF) = 300+112 = 412. After 9 ticks idx = 0.
- alien_alive→0 in LEFT → fleet_cleared=1, move_left stays 1 across ticks. Pixel tick held 4 clks → exactly one update.
